// File: rtl/bip_ctrl_pkg.sv
// Shared types and constants for the BIP host-side run controller.
package bip_ctrl_pkg;

    // Sequencer states
    typedef enum logic [3:0] {
        StIdle,
        StLdNHi,
        StLdNLo,
        StLdWHi,
        StLdWLo,
        StLdWr,
        StRun,
        StSnap,
        StTx,
        StTxAck
    } ctrl_state_e;

    localparam logic [7:0] CMD_LOAD = 8'h4C;  // 'L'
    localparam logic [7:0] CMD_RUN  = 8'h52;  // 'R'
    localparam logic [7:0] ACK_LOAD = 8'h4B;  // 'K'

    // Report is {acc[15:0], cnt[15:0]}, sent MSB first
    localparam int unsigned REPORT_BYTES = 4;
    localparam int unsigned REPORT_W     = 8 * REPORT_BYTES;
    localparam int unsigned IDX_W        = $clog2(REPORT_BYTES);

endpackage

// File: rtl/bip_tx_serializer.sv
// Sends a latched multi-byte report MSB first over a valid/ready byte handshake.
module bip_tx_serializer
    import bip_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic [REPORT_W-1:0] report,
    input  logic                load,
    output logic [7:0]          tx_data,
    output logic                tx_valid,
    input  logic                tx_ready,
    output logic                done
);

    logic [REPORT_W-1:0] shift_q;
    logic [IDX_W-1:0]    idx_q;
    logic                valid_q;
    logic                last_byte;

    assign last_byte = (idx_q == IDX_W'(REPORT_BYTES - 1));

    // Latch report on load, then advance one byte per accepted transfer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_q <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
        end else if (load) begin
            shift_q <= report;
            idx_q   <= '0;
            valid_q <= 1'b1;
        end else if (valid_q && tx_ready) begin
            if (last_byte) begin
                valid_q <= 1'b0;
            end else begin
                shift_q <= shift_q << 8;
                idx_q   <= idx_q + IDX_W'(1);
            end
        end
    end

    // Data comes straight from the register, so it cannot move while stalled
    assign tx_data  = shift_q[REPORT_W-1 -: 8];
    assign tx_valid = valid_q;
    assign done     = valid_q & tx_ready & last_byte;

endmodule

// File: rtl/bip_run_controller.sv
// Host-side load/run/report sequencer between the UART byte interface and the BIP CPU.
module bip_run_controller
    import bip_ctrl_pkg::*;
#(
    parameter int unsigned PC_W   = 11,
    parameter int unsigned INST_W = 16,
    parameter int unsigned ACC_W  = 16,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              pm_we,
    output logic [PC_W-1:0]   pm_addr,
    output logic [INST_W-1:0] pm_wdata,
    output logic              bip_enable,
    input  logic              bip_halt,
    input  logic [ACC_W-1:0]  bip_acc,
    output logic              busy
);

    ctrl_state_e      state_q;
    logic [7:0]       hi_q;      // pending high byte of count or instruction
    logic [15:0]      n_q;       // words to load
    logic [15:0]      wr_cnt_q;  // words written so far
    logic [CNT_W-1:0] cnt_q;     // saturating cycle counter
    logic             ack_q;

    logic [15:0]      cnt_ext;
    logic [7:0]       ser_data;
    logic             ser_valid;
    logic             ser_done;
    logic             ser_load;

    // Counter is reported as a 16-bit field regardless of CNT_W
    always_comb begin
        cnt_ext              = '0;
        cnt_ext[CNT_W-1:0]   = cnt_q;
    end

    // The serializer's shift register is the report latch; it captures in SNAP
    assign ser_load = (state_q == StSnap);

    bip_tx_serializer u_tx_serializer (
        .clk      (clk),
        .reset    (reset),
        .report   ({bip_acc, cnt_ext}),
        .load     (ser_load),
        .tx_data  (ser_data),
        .tx_valid (ser_valid),
        .tx_ready (tx_ready),
        .done     (ser_done)
    );

    // Load/run/report sequencer with registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            hi_q       <= '0;
            n_q        <= '0;
            wr_cnt_q   <= '0;
            cnt_q      <= '0;
            ack_q      <= 1'b0;
            pm_we      <= 1'b0;
            pm_addr    <= '0;
            pm_wdata   <= '0;
            bip_enable <= 1'b0;
        end else begin
            pm_we <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (rx_valid) begin
                        if (rx_data == CMD_LOAD) begin
                            state_q <= StLdNHi;
                        end else if (rx_data == CMD_RUN) begin
                            state_q    <= StRun;
                            cnt_q      <= '0;
                            bip_enable <= 1'b1;
                        end
                    end
                end
                StLdNHi: begin
                    if (rx_valid) begin
                        hi_q    <= rx_data;
                        state_q <= StLdNLo;
                    end
                end
                StLdNLo: begin
                    if (rx_valid) begin
                        n_q      <= {hi_q, rx_data};
                        pm_addr  <= '0;
                        wr_cnt_q <= '0;
                        if ({hi_q, rx_data} == 16'd0) begin
                            ack_q   <= 1'b1;
                            state_q <= StTxAck;
                        end else begin
                            state_q <= StLdWHi;
                        end
                    end
                end
                StLdWHi: begin
                    if (rx_valid) begin
                        hi_q    <= rx_data;
                        state_q <= StLdWLo;
                    end
                end
                StLdWLo: begin
                    if (rx_valid) begin
                        pm_wdata <= INST_W'({hi_q, rx_data});
                        pm_we    <= 1'b1;
                        state_q  <= StLdWr;
                    end
                end
                StLdWr: begin
                    // Write happens this cycle; address wraps naturally at 2^PC_W
                    pm_addr  <= pm_addr + PC_W'(1);
                    wr_cnt_q <= wr_cnt_q + 16'd1;
                    if ((wr_cnt_q + 16'd1) == n_q) begin
                        ack_q   <= 1'b1;
                        state_q <= StTxAck;
                    end else begin
                        state_q <= StLdWHi;
                    end
                end
                StRun: begin
                    if (cnt_q != {CNT_W{1'b1}}) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                    if (bip_halt) begin
                        bip_enable <= 1'b0;
                        state_q    <= StSnap;
                    end
                end
                StSnap: begin
                    state_q <= StTx;
                end
                StTx: begin
                    if (ser_done) begin
                        state_q <= StIdle;
                    end
                end
                StTxAck: begin
                    if (tx_ready) begin
                        ack_q   <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Ack and report never overlap; idle data reads as zero
    assign tx_valid = ack_q | ser_valid;
    assign tx_data  = ack_q ? ACK_LOAD : (ser_valid ? ser_data : 8'h00);
    assign busy     = (state_q != StIdle);

endmodule
